counter_updown_mod: RTL and testbench

Parametrised up/down modulo counter. It is the successor to the team's 4-bit up-counter with load.
- Adds programmable limit, wrap or saturate mode, prescaled stepping, down counting, a terminal-count strobe and a sticky overflow flag.
- Used as a general event/timer counter in lab datapaths. Single clock domain.

---
 rtl/counter_updown_mod.sv | 134 +++++++++++++
 tb/tb_counter_updown_mod.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Parametrised up/down modulo counter with programmable limit, wrap or
// saturate boundary behaviour, prescaled stepping, a registered one-cycle
// terminal-count strobe and a sticky overflow flag.
//
// Ports:
//   CLK        in   1           clock, rising edge
//   RESET      in   1           asynchronous active-high reset
//   Invalue    in   WIDTH       parallel load value (clamped to Limit)
//   Load       in   1           synchronous load strobe (highest priority)
//   UP         in   1           count-up request
//   DOWN       in   1           count-down request
//   Enable     in   1           global count enable
//   Mode       in   1           0 = wrap, 1 = saturate
//   Limit      in   WIDTH       upper bound of the count range 0..Limit
//   Prescale   in   PRESCALE_W  step every Prescale+1 qualifying cycles
//   Clear_ovf  in   1           synchronous clear of OVF
//   Count      out  WIDTH       current count, registered
//   FULL       out  1           Count >= Limit (combinational decode)
//   EMPTY      out  1           Count == 0 (combinational decode)
//   TC         out  1           terminal-count pulse, registered
//   OVF        out  1           sticky boundary-hit flag, registered
// -----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      Invalue,
    input  logic                  Load,
    input  logic                  UP,
    input  logic                  DOWN,
    input  logic                  Enable,
    input  logic                  Mode,
    input  logic [WIDTH-1:0]      Limit,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Clear_ovf,
    output logic [WIDTH-1:0]      Count,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  TC,
    output logic                  OVF
);

    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_tc;
    logic                  r_ovf;

    logic [WIDTH-1:0]      w_count_nxt;
    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic                  w_tc_nxt;
    logic                  w_ovf_nxt;
    logic                  w_bnd;
    logic                  w_qual;
    logic [WIDTH-1:0]      w_load_val;

    // A qualifying cycle needs exactly one direction request; UP=DOWN=1 holds.
    assign w_qual     = !Load && Enable && (UP ^ DOWN);
    assign w_load_val = (Invalue > Limit) ? Limit : Invalue;

    // Next-state decode: Load > prescaled step > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_bnd       = 1'b0;
        if (Load) begin
            w_count_nxt = w_load_val;
            w_presc_nxt = {PRESCALE_W{1'b0}};
        end else if (w_qual) begin
            if (r_presc == Prescale) begin
                w_presc_nxt = {PRESCALE_W{1'b0}};
                if (UP) begin
                    if (r_count >= Limit) begin
                        w_bnd       = 1'b1;
                        w_count_nxt = Mode ? Limit : {WIDTH{1'b0}};
                    end else begin
                        w_count_nxt = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    if (r_count == {WIDTH{1'b0}}) begin
                        w_bnd       = 1'b1;
                        w_count_nxt = Mode ? {WIDTH{1'b0}} : Limit;
                    end else if (r_count > Limit) begin
                        // Limit was lowered under a running count: snap back into range.
                        w_count_nxt = Limit;
                    end else begin
                        w_count_nxt = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end else begin
                // Free-running increment; wraps at all-ones if Prescale was lowered below it.
                w_presc_nxt = r_presc + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            w_count_nxt = r_count;
            w_presc_nxt = r_presc;
        end
        w_tc_nxt = w_bnd;
        // A boundary hit on the same edge wins over the clear request.
        if (w_bnd) begin
            w_ovf_nxt = 1'b1;
        end else if (Clear_ovf) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= {WIDTH{1'b0}};
            r_presc <= {PRESCALE_W{1'b0}};
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign Count = r_count;
    assign TC    = r_tc;
    assign OVF   = r_ovf;
    // FULL uses >= so a count stranded above a lowered Limit still reads full.
    assign FULL  = (r_count >= Limit);
    assign EMPTY = (r_count == {WIDTH{1'b0}});

endmodule

// File: tb/tb_counter_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_mod
// Self-checking bench for counter_updown_mod (WIDTH=8, PRESCALE_W=4).
// A behavioural reference predicts each edge; predictions are queued when
// stimulus is applied and popped/compared after the edge.
// -----------------------------------------------------------------------------
module tb_counter_updown_mod;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] Invalue;
    logic       Load;
    logic       UP;
    logic       DOWN;
    logic       Enable;
    logic       Mode;
    logic [7:0] Limit;
    logic [3:0] Prescale;
    logic       Clear_ovf;
    logic [7:0] Count;
    logic       FULL;
    logic       EMPTY;
    logic       TC;
    logic       OVF;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int count;
        int tc;
        int ovf;
        int full;
        int empty;
    } exp_t;

    exp_t exp_q[$];

    int m_count;
    int m_presc;
    int m_tc;
    int m_ovf;

    counter_updown_mod #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Invalue   (Invalue),
        .Load      (Load),
        .UP        (UP),
        .DOWN      (DOWN),
        .Enable    (Enable),
        .Mode      (Mode),
        .Limit     (Limit),
        .Prescale  (Prescale),
        .Clear_ovf (Clear_ovf),
        .Count     (Count),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .TC        (TC),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: advance one edge using current inputs.
    task automatic model_step();
        int bnd;
        bnd = 0;
        if (Load) begin
            m_count = (int'(Invalue) > int'(Limit)) ? int'(Limit) : int'(Invalue);
            m_presc = 0;
        end else if (Enable && (UP != DOWN)) begin
            if (m_presc == int'(Prescale)) begin
                m_presc = 0;
                if (UP) begin
                    if (m_count >= int'(Limit)) begin
                        bnd = 1;
                        m_count = Mode ? int'(Limit) : 0;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else begin
                    if (m_count == 0) begin
                        bnd = 1;
                        m_count = Mode ? 0 : int'(Limit);
                    end else if (m_count > int'(Limit)) begin
                        m_count = int'(Limit);
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end else begin
                m_presc = (m_presc + 1) % 16;
            end
        end
        m_tc = bnd;
        if (bnd == 1)       m_ovf = 1;
        else if (Clear_ovf) m_ovf = 0;
    endtask

    // Predict, push, clock, then pop and compare every output.
    task automatic cycle();
        exp_t e;
        model_step();
        e.count = m_count;
        e.tc    = m_tc;
        e.ovf   = m_ovf;
        e.full  = (m_count >= int'(Limit)) ? 1 : 0;
        e.empty = (m_count == 0) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_val("sb_count", int'(Count), e.count);
        check_val("sb_tc",    int'(TC),    e.tc);
        check_val("sb_ovf",   int'(OVF),   e.ovf);
        check_val("sb_full",  int'(FULL),  e.full);
        check_val("sb_empty", int'(EMPTY), e.empty);
    endtask

    task automatic idle_inputs();
        Load = 1'b0; UP = 1'b0; DOWN = 1'b0; Enable = 1'b0; Clear_ovf = 1'b0;
    endtask

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_tc = 0; m_ovf = 0;
    endtask

    initial begin
        int seq;
        RESET = 1'b1; Invalue = 8'd0; Mode = 1'b0; Limit = 8'd200; Prescale = 4'd0;
        idle_inputs();
        model_reset();
        #2;
        check_val("rst_count", int'(Count), 0);
        check_val("rst_empty", int'(EMPTY), 1);
        check_val("rst_full",  int'(FULL),  0);
        #1 RESET = 1'b0;
        cycle();

        // Reset mid-count at 37
        Enable = 1'b1; UP = 1'b1;
        for (int i = 0; i < 37; i++) cycle();
        check_val("pre_rst_count", int'(Count), 37);
        idle_inputs();
        #3 RESET = 1'b1;
        #1;
        model_reset();
        check_val("mid_rst_count", int'(Count), 0);
        check_val("mid_rst_tc",    int'(TC),    0);
        check_val("mid_rst_ovf",   int'(OVF),   0);
        check_val("mid_rst_empty", int'(EMPTY), 1);
        #2 RESET = 1'b0;
        cycle();

        // Wrap up with Limit=9
        Limit = 8'd9; Mode = 1'b0; Prescale = 4'd0; Enable = 1'b1; UP = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            seq = (i < 9) ? i + 1 : i - 9;
            check_val("wrap_count", int'(Count), seq);
            check_val("wrap_tc",    int'(TC),    (i == 9) ? 1 : 0);
            check_val("wrap_full",  int'(FULL),  (seq == 9) ? 1 : 0);
        end
        check_val("wrap_ovf", int'(OVF), 1);

        // Saturate down with Prescale=2
        UP = 1'b0; Load = 1'b1; Invalue = 8'd3; Mode = 1'b1; Prescale = 4'd2;
        cycle();
        check_val("sat_load", int'(Count), 3);
        Load = 1'b0; DOWN = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            check_val("sat_count", int'(Count), (3 - k / 3 > 0) ? 3 - k / 3 : 0);
            check_val("sat_tc",    int'(TC),    (k % 3 == 0 && k >= 12) ? 1 : 0);
        end
        check_val("sat_ovf", int'(OVF), 1);

        // Load clamp and priority over UP
        DOWN = 1'b0; Mode = 1'b0; Prescale = 4'd0; Limit = 8'd50;
        Load = 1'b1; Invalue = 8'd80; UP = 1'b1;
        cycle();
        check_val("clamp_count", int'(Count), 50);
        check_val("clamp_tc",    int'(TC),    0);
        check_val("clamp_full",  int'(FULL),  1);
        Load = 1'b0;
        cycle();
        check_val("clamp_wrap_count", int'(Count), 0);
        check_val("clamp_wrap_tc",    int'(TC),    1);

        // Frozen prescaler under conflicting requests / disable
        UP = 1'b0; Load = 1'b1; Invalue = 8'd20;
        cycle();
        Load = 1'b0; Prescale = 4'd3;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin Enable = 1'b1; UP = 1'b1; DOWN = 1'b1; end
            else       begin Enable = 1'b0; UP = 1'b1; DOWN = 1'b0; end
            cycle();
            check_val("freeze_count", int'(Count), 20);
        end
        Enable = 1'b1; UP = 1'b1; DOWN = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cycle();
            check_val("resume_count", int'(Count), (j == 4) ? 21 : 20);
        end

        // Down wrap from 0 to Limit
        Prescale = 4'd0; UP = 1'b0; Load = 1'b1; Invalue = 8'd0;
        cycle();
        Load = 1'b0; DOWN = 1'b1;
        cycle();
        check_val("dwrap_count", int'(Count), 50);
        check_val("dwrap_tc",    int'(TC),    1);

        // Limit lowered below the count, then step down
        DOWN = 1'b0; Load = 1'b1; Invalue = 8'd40;
        cycle();
        Load = 1'b0; Limit = 8'd10;
        #1;
        check_val("lowlim_full", int'(FULL), 1);
        DOWN = 1'b1;
        cycle();
        check_val("lowlim_count", int'(Count), 10);
        check_val("lowlim_tc",    int'(TC),    0);

        // OVF clear vs. boundary set on the same edge
        DOWN = 1'b0; Limit = 8'd15; Load = 1'b1; Invalue = 8'd15;
        cycle();
        Load = 1'b0; Enable = 1'b0; Clear_ovf = 1'b1;
        cycle();
        check_val("ovf_cleared", int'(OVF), 0);
        Enable = 1'b1; UP = 1'b1;
        cycle();
        check_val("race_ovf",   int'(OVF),   1);
        check_val("race_count", int'(Count), 0);
        UP = 1'b0;
        cycle();
        check_val("clear_ovf", int'(OVF), 0);

        check_val("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
